fix2flt_arbiter: RTL and testbench

FIX2FLT_ARBITER -- requirements
Module: fix2flt_arbiter

---
 rtl/fix2flt_arbiter_if.sv | 34 +++
 rtl/fix2flt_arbiter.sv | 104 ++++++++++
 tb/tb_fix2flt_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fix2flt_arbiter_if.sv
// Two-requester conversion request bus and single result channel
// for the fixed-point to float arbiter.
interface fix2flt_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_number;
    logic [4:0]  req0_fixpos;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_number;
    logic [4:0]  req1_fixpos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_id;

    modport slave (
        input  req0_valid, req0_number, req0_fixpos,
        output req0_ready,
        input  req1_valid, req1_number, req1_fixpos,
        output req1_ready,
        output out_valid, out_result, out_id,
        input  out_ready
    );

    modport master (
        output req0_valid, req0_number, req0_fixpos,
        input  req0_ready,
        output req1_valid, req1_number, req1_fixpos,
        input  req1_ready,
        input  out_valid, out_result, out_id,
        output out_ready
    );
endinterface

// File: rtl/fix2flt_arbiter.sv
// Round-robin shared converter: signed fixed-point to IEEE-754 single,
// one bit of normalisation per cycle, truncating mantissa.
module fix2flt_arbiter (
    input  logic               clk,
    input  logic               rst,
    fix2flt_arbiter_if.slave   bus,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] num_q;
    logic [31:0] mag_q;
    logic [31:0] mag_abs;
    logic [31:0] num_sel;
    logic [4:0]  fix_q;
    logic [4:0]  fix_sel;
    logic [5:0]  s_q;
    logic        sign_q;
    logic        id_q;
    logic        zero_q;
    logic        last_q;
    logic [31:0] result_q;
    logic        out_id_q;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [7:0]  exp_w;

    // last_q names the requester granted most recently; the other wins a tie
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1 = bus.req1_valid & ~grant0;

    assign bus.req0_ready = (state == IDLE) & grant0;
    assign bus.req1_ready = (state == IDLE) & grant1;
    assign accept         = bus.req0_ready | bus.req1_ready;

    assign num_sel = grant1 ? bus.req1_number : bus.req0_number;
    assign fix_sel = grant1 ? bus.req1_fixpos : bus.req0_fixpos;

    assign mag_abs = sign_q ? (~num_q + 32'd1) : num_q;
    assign exp_w   = 8'd158 - {2'b00, s_q} - {3'b000, fix_q};

    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result_q;
    assign bus.out_id     = out_id_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = ABS;
            ABS:  state_nx = (mag_abs == 32'd0) ? PACK : NORM;
            NORM: if (mag_q[31]) state_nx = PACK;
            PACK: state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q    <= '0;
            mag_q    <= '0;
            fix_q    <= '0;
            s_q      <= '0;
            sign_q   <= 1'b0;
            id_q     <= 1'b0;
            zero_q   <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            out_id_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    num_q  <= num_sel;
                    fix_q  <= fix_sel;
                    sign_q <= num_sel[31];
                    id_q   <= grant1;
                    last_q <= grant1;
                end
                ABS: begin
                    mag_q  <= mag_abs;
                    zero_q <= (mag_abs == 32'd0);
                    s_q    <= '0;
                end
                NORM: if (!mag_q[31]) begin
                    mag_q <= mag_q << 1;
                    s_q   <= s_q + 6'd1;
                end
                PACK: begin
                    result_q <= zero_q ? 32'd0 : {sign_q, exp_w, mag_q[30:8]};
                    out_id_q <= id_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fix2flt_arbiter.sv
// Directed self-checking bench for fix2flt_arbiter.
module tb_fix2flt_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fix2flt_arbiter_if bus();

    fix2flt_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic idle_inputs;
        bus.req0_valid  = 1'b0;
        bus.req0_number = '0;
        bus.req0_fixpos = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_number = '0;
        bus.req1_fixpos = '0;
    endtask

    // drive one request and wait for its result; lat counts edges after acceptance
    task automatic convert(input bit id, input logic [31:0] num,
                           input logic [4:0] fp, output int lat, output bit ok);
        bit acc;
        acc = 1'b0;
        ok  = 1'b0;
        lat = 0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_number = num; bus.req1_fixpos = fp;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_number = num; bus.req0_fixpos = fp;
        end
        for (int i = 0; i < 60 && !acc; i++) begin
            #1;
            acc = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); #1;
        end
        idle_inputs();
        if (acc) begin
            for (int i = 0; i < 100 && !bus.out_valid; i++) begin
                @(posedge clk); #1;
                lat++;
            end
            ok = bus.out_valid;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags out_valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
        total++;
        if (bus.out_result !== 32'h0 || bus.out_id !== 1'b0) begin
            bad++; $display("FAIL reset_outs result=%h id=%b want 00000000 0", bus.out_result, bus.out_id);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_tie r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        idle_inputs();
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_single;
        int lat; bit ok;
        bus.out_ready = 1'b1;
        convert(1'b0, 32'h0000_0180, 5'd8, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 26) begin
            bad++; $display("FAIL single_lat ok=%b lat=%0d want 1 26", ok, lat);
        end
        total++;
        if (bus.out_result !== 32'h3FC0_0000 || bus.out_id !== 1'b0) begin
            bad++; $display("FAIL single_res result=%h id=%b want 3fc00000 0", bus.out_result, bus.out_id);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL single_busy busy=%b want 1", busy);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_exit out_valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_negative;
        int lat; bit ok;
        bus.out_ready = 1'b1;
        convert(1'b1, 32'hFFFF_FE80, 5'd8, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 26) begin
            bad++; $display("FAIL neg_lat ok=%b lat=%0d want 1 26", ok, lat);
        end
        total++;
        if (bus.out_result !== 32'hBFC0_0000 || bus.out_id !== 1'b1) begin
            bad++; $display("FAIL neg_res result=%h id=%b want bfc00000 1", bus.out_result, bus.out_id);
        end
    endtask

    task automatic test_min_latency;
        int lat; bit ok;
        bus.out_ready = 1'b1;
        convert(1'b0, 32'h8000_0000, 5'd0, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 3) begin
            bad++; $display("FAIL min_lat ok=%b lat=%0d want 1 3", ok, lat);
        end
        total++;
        if (bus.out_result !== 32'hCF00_0000) begin
            bad++; $display("FAIL min_res result=%h want cf000000", bus.out_result);
        end
    endtask

    task automatic test_max_shift;
        int lat; bit ok;
        bus.out_ready = 1'b1;
        convert(1'b0, 32'h0000_0001, 5'd31, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 34) begin
            bad++; $display("FAIL maxs_lat ok=%b lat=%0d want 1 34", ok, lat);
        end
        total++;
        if (bus.out_result !== 32'h3000_0000) begin
            bad++; $display("FAIL maxs_res result=%h want 30000000", bus.out_result);
        end
    endtask

    task automatic test_zero;
        int lat; bit ok;
        bus.out_ready = 1'b1;
        convert(1'b0, 32'h0000_0000, 5'd5, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 2) begin
            bad++; $display("FAIL zero_lat ok=%b lat=%0d want 1 2", ok, lat);
        end
        total++;
        if (bus.out_result !== 32'h0000_0000) begin
            bad++; $display("FAIL zero_res result=%h want 00000000", bus.out_result);
        end
    endtask

    task automatic test_arbitration;
        logic [31:0] want;
        int g;
        bit both;
        bit seen;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.out_ready   = 1'b0;
        bus.req0_valid  = 1'b1;
        bus.req0_number = 32'h0000_0180;
        bus.req0_fixpos = 5'd8;
        bus.req1_valid  = 1'b1;
        bus.req1_number = 32'hFFFF_FE80;
        bus.req1_fixpos = 5'd8;
        for (int k = 0; k < 4; k++) begin
            g = -1; both = 1'b0; seen = 1'b0;
            for (int i = 0; i < 60 && g < 0; i++) begin
                #1;
                if (bus.req0_ready && bus.req1_ready) both = 1'b1;
                if (bus.req0_ready) g = 0;
                else if (bus.req1_ready) g = 1;
                @(posedge clk); #1;
            end
            total++;
            if (g != (k % 2) || both) begin
                bad++; $display("FAIL arb_grant%0d got=%0d both=%b want %0d", k, g, both, k % 2);
            end
            for (int i = 0; i < 100 && !bus.out_valid; i++) begin
                @(posedge clk); #1;
            end
            want = (k % 2) ? 32'hBFC0_0000 : 32'h3FC0_0000;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== want || bus.out_id !== k[0]) begin
                bad++;
                $display("FAIL arb_res%0d valid=%b result=%h id=%b want 1 %h %b",
                         k, bus.out_valid, bus.out_result, bus.out_id, want, k[0]);
            end
            for (int n = 0; n < ((k == 0) ? 5 : 1); n++) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b1 || bus.out_result !== want ||
                    bus.req0_ready || bus.req1_ready) seen = 1'b1;
            end
            total++;
            if (seen) begin
                bad++;
                $display("FAIL arb_stall%0d valid=%b result=%h r0=%b r1=%b want 1 %h 0 0",
                         k, bus.out_valid, bus.out_result, bus.req0_ready, bus.req1_ready, want);
            end
            bus.out_ready = 1'b1;
            #1;
            total++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++; $display("FAIL arb_exit_ready%0d r0=%b r1=%b want 0 0", k, bus.req0_ready, bus.req1_ready);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL arb_taken%0d out_valid=%b want 0", k, bus.out_valid);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_norm;
        int lat; bit ok; bit acc; int spur;
        acc = 1'b0; spur = 0;
        bus.out_ready   = 1'b1;
        bus.req0_valid  = 1'b1;
        bus.req0_number = 32'h0000_0800;
        bus.req0_fixpos = 5'd0;
        for (int i = 0; i < 60 && !acc; i++) begin
            #1;
            acc = bus.req0_ready;
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (!acc || busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL midnorm_run acc=%b busy=%b valid=%b want 1 1 0", acc, busy, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midnorm_rst valid=%b busy=%b want 0 0", bus.out_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) spur++;
        end
        total++;
        if (spur != 0) begin
            bad++; $display("FAIL midnorm_spur out_valid_cycles=%0d want 0", spur);
        end
        convert(1'b0, 32'h0000_0800, 5'd0, lat, ok);
        total++;
        if (ok !== 1'b1 || lat != 23 || bus.out_result !== 32'h4500_0000) begin
            bad++; $display("FAIL midnorm_after ok=%b lat=%0d result=%h want 1 23 45000000", ok, lat, bus.out_result);
        end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_single();
        test_negative();
        test_min_latency();
        test_max_shift();
        test_zero();
        test_arbitration();
        test_reset_mid_norm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
